// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the five-stage pipeline.
//
// Takes the EX/MEM pipeline-register outputs, drives a request/acknowledge
// data-memory port, resolves branches and loads the MEM/WB register that
// feeds write-back. While an access is outstanding the upstream pipeline is
// held with `stall`. A wait counter aborts accesses that never complete.
//
// Parameters
//   TIMEOUT   : maximum wait cycles after the first request cycle before the
//               access is aborted; 0 disables the timeout.
//
// Build option
//   MEM_MISALIGN_CHECK_EN : when defined, accesses with ALURes[1:0] != 0 are
//               not issued; they retire at once with write-back suppressed
//               and a one-cycle `misalign` pulse. When undefined, no
//               alignment check is done and `misalign` is tied low.
//
// Ports
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   WB[1:0]           : {RegWrite, MemtoReg} from EX/MEM
//   M[2:0]            : {Branch, MemRead, MemWrite} from EX/MEM
//   ALURes[31:0]      : effective address / ALU result
//   DataIn[31:0]      : store data
//   RdRt[4:0]         : destination register
//   zero              : ALU zero flag
//   dmem_req/we/addr/wdata (out), dmem_rdata/ack (in) : data-memory port
//   stall             : holds upstream stages and EX/MEM while high
//   PCSrc             : branch taken
//   WBReg, ReadData, ALUReg, RdRtReg : MEM/WB register outputs
//   bus_err           : one-cycle pulse on a timeout abort
//   misalign          : one-cycle pulse on a rejected misaligned access
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  WB,
  input  logic [2:0]  M,
  input  logic [31:0] ALURes,
  input  logic [31:0] DataIn,
  input  logic [4:0]  RdRt,
  input  logic        zero,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        PCSrc,
  output logic [1:0]  WBReg,
  output logic [31:0] ReadData,
  output logic [31:0] ALUReg,
  output logic [4:0]  RdRtReg,
  output logic        bus_err,
  output logic        misalign
);

  // A zero TIMEOUT still needs a one-bit counter to keep widths legal.
  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam bit            TO_EN  = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    wb_q,    wb_d;
  logic [31:0]   rd_q,    rd_d;
  logic [31:0]   alu_q,   alu_d;
  logic [4:0]    rdrt_q,  rdrt_d;

  logic access_s;
  logic misal_s;
  logic stall_s;
  logic abort_s;

  assign access_s = M[1] | M[0];

`ifdef MEM_MISALIGN_CHECK_EN
  // Only a fresh access in IDLE can be rejected; BUSY was entered aligned
  // and its inputs are held stable by the stall.
  assign misal_s = access_s && (ALURes[1:0] != 2'b00) && (state_q == IDLE);
`else
  assign misal_s = 1'b0;
`endif

  assign dmem_req   = (state_q == BUSY) | (access_s & ~misal_s);
  assign dmem_we    = M[0];   // MemWrite wins over MemRead
  assign dmem_addr  = ALURes;
  assign dmem_wdata = DataIn;

  assign PCSrc = M[2] & zero & (state_q == IDLE);

  // Status outputs are forced low while reset is asserted.
  assign stall    = rst_n & stall_s;
  assign bus_err  = rst_n & abort_s;
  assign misalign = rst_n & misal_s;

  assign WBReg    = wb_q;
  assign ReadData = rd_q;
  assign ALUReg   = alu_q;
  assign RdRtReg  = rdrt_q;

  // Next-state and MEM/WB next-value selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    rdrt_d  = rdrt_q;
    stall_s = 1'b0;
    abort_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (!access_s) begin
          // Non-memory instruction passes straight through.
          wb_d   = WB;
          rd_d   = 32'd0;
          alu_d  = ALURes;
          rdrt_d = RdRt;
        end else if (misal_s) begin
          // Rejected without a request: retire with write-back suppressed.
          wb_d = 2'b00;
          rd_d = 32'd0;
        end else if (dmem_ack) begin
          wb_d   = WB;
          rd_d   = M[0] ? 32'd0 : dmem_rdata;
          alu_d  = ALURes;
          rdrt_d = RdRt;
        end else begin
          stall_s = 1'b1;
          state_d = BUSY;
          cnt_d   = CW'(1);
          wb_d    = 2'b00;   // bubble
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          // Ack wins even on the cycle the counter reaches its limit.
          wb_d    = WB;
          rd_d    = M[0] ? 32'd0 : dmem_rdata;
          alu_d   = ALURes;
          rdrt_d  = RdRt;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (TO_EN && (cnt_q == CNT_MAX)) begin
          abort_s = 1'b1;
          wb_d    = 2'b00;
          rd_d    = 32'd0;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          wb_d    = 2'b00;   // bubble
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, wait counter and MEM/WB register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= 2'b00;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      rdrt_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      rdrt_q  <= rdrt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed, self-checking bench for mem_stage (TIMEOUT = 4).
// Expected MEM/WB contents are queued when an instruction is presented and
// compared after the edge at which the stage retires it.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [31:0] ALURes;
  logic [31:0] DataIn;
  logic [4:0]  RdRt;
  logic        zero;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        PCSrc;
  logic [1:0]  WBReg;
  logic [31:0] ReadData;
  logic [31:0] ALUReg;
  logic [4:0]  RdRtReg;
  logic        bus_err;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  int n_req, n_stall, n_berr;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rdrt;
  } mw_t;

  mw_t sb_q[$];

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .WB(WB), .M(M), .ALURes(ALURes), .DataIn(DataIn),
    .RdRt(RdRt), .zero(zero), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .PCSrc(PCSrc), .WBReg(WBReg),
    .ReadData(ReadData), .ALUReg(ALUReg), .RdRtReg(RdRtReg),
    .bus_err(bus_err), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] din, input logic [4:0] rdrt, input logic z,
                       input logic ack, input logic [31:0] rdata);
    WB = wb; M = m; ALURes = alu; DataIn = din; RdRt = rdrt; zero = z;
    dmem_ack = ack; dmem_rdata = rdata;
  endtask

  task automatic sb_check(input string tag);
    mw_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".WBReg"},    32'(WBReg),   32'(e.wb));
      chk({tag, ".ReadData"}, ReadData,     e.rd);
      chk({tag, ".ALUReg"},   ALUReg,       e.alu);
      chk({tag, ".RdRtReg"},  32'(RdRtReg), 32'(e.rdrt));
    end
  endtask

  initial begin
    // Reset for two edges with a load pending and no ack.
    rst_n = 1'b0;
    drive(2'b11, 3'b010, 32'h40, 32'h0, 5'd7, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.WBReg",    32'(WBReg),   32'd0);
    chk("rst.ReadData", ReadData,     32'd0);
    chk("rst.ALUReg",   ALUReg,       32'd0);
    chk("rst.RdRtReg",  32'(RdRtReg), 32'd0);
    chk("rst.stall",    32'(stall),   32'd0);
    chk("rst.bus_err",  32'(bus_err), 32'd0);
    chk("rst.dmem_req", 32'(dmem_req), 32'd1);

    // Branch in IDLE, zero = 1; stray ack without request is ignored.
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, 3'b100, 32'h24, 32'h0, 5'd2, 1'b1, 1'b1, 32'h55);
    sb_q.push_back('{wb: 2'b10, rd: 32'd0, alu: 32'h24, rdrt: 5'd2});
    #1;
    chk("br1.PCSrc",    32'(PCSrc),    32'd1);
    chk("br1.dmem_req", 32'(dmem_req), 32'd0);
    chk("br1.stall",    32'(stall),    32'd0);
    @(posedge clk); #1;
    sb_check("br1");

    // Branch with zero = 0.
    @(negedge clk);
    drive(2'b00, 3'b100, 32'h28, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    sb_q.push_back('{wb: 2'b00, rd: 32'd0, alu: 32'h28, rdrt: 5'd0});
    #1;
    chk("br0.PCSrc", 32'(PCSrc), 32'd0);
    @(posedge clk); #1;
    sb_check("br0");

    // Single-cycle load.
    @(negedge clk);
    drive(2'b11, 3'b010, 32'h40, 32'h0, 5'd8, 1'b0, 1'b1, 32'hDEADBEEF);
    sb_q.push_back('{wb: 2'b11, rd: 32'hDEADBEEF, alu: 32'h40, rdrt: 5'd8});
    #1;
    chk("ld.dmem_req",  32'(dmem_req), 32'd1);
    chk("ld.dmem_we",   32'(dmem_we),  32'd0);
    chk("ld.dmem_addr", dmem_addr,     32'h40);
    chk("ld.stall",     32'(stall),    32'd0);
    @(posedge clk); #1;
    sb_check("ld");

    // Store acked 3 cycles after the first request cycle.
    n_stall = 0;
    @(negedge clk);
    drive(2'b10, 3'b001, 32'h80, 32'h1234, 5'd3, 1'b0, 1'b0, 32'hCAFEF00D);
    sb_q.push_back('{wb: 2'b10, rd: 32'd0, alu: 32'h80, rdrt: 5'd3});
    #1;
    chk("st.dmem_we",    32'(dmem_we), 32'd1);
    chk("st.dmem_wdata", dmem_wdata,   32'h1234);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      dmem_ack = (i == 3);
      #1;
      if (stall) n_stall++;
      @(posedge clk); #1;
      if (i < 3) begin
        chk("st.bubble.WBReg",   32'(WBReg), 32'd0);
        chk("st.hold.ReadData",  ReadData,   32'hDEADBEEF);
      end
    end
    sb_check("st");
    chk("st.stall_cycles", 32'(n_stall), 32'd3);

    // Load that never acks: TIMEOUT+1 request cycles then abort.
    n_req = 0; n_stall = 0; n_berr = 0;
    @(negedge clk);
    drive(2'b11, 3'b010, 32'h100, 32'h0, 5'd5, 1'b0, 1'b0, 32'h0);
    sb_q.push_back('{wb: 2'b00, rd: 32'd0, alu: 32'h80, rdrt: 5'd3});
    for (int i = 0; i < TO + 1; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (dmem_req) n_req++;
      if (stall)    n_stall++;
      if (bus_err)  n_berr++;
      @(posedge clk); #1;
    end
    sb_check("to");
    chk("to.req_cycles",   32'(n_req),   32'(TO + 1));
    chk("to.stall_cycles", 32'(n_stall), 32'(TO));
    chk("to.bus_err_cnt",  32'(n_berr),  32'd1);
    @(negedge clk);
    drive(2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
    sb_q.push_back('{wb: 2'b00, rd: 32'd0, alu: 32'h0, rdrt: 5'd0});
    #1;
    chk("to.idle.PCSrc",   32'(PCSrc),   32'd1);
    chk("to.idle.bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    sb_check("to.idle");

    // Ack arriving on the cycle the counter hits TIMEOUT completes normally.
    n_berr = 0;
    @(negedge clk);
    drive(2'b11, 3'b010, 32'h200, 32'h0, 5'd9, 1'b0, 1'b0, 32'h600DF00D);
    sb_q.push_back('{wb: 2'b11, rd: 32'h600DF00D, alu: 32'h200, rdrt: 5'd9});
    for (int i = 0; i < TO + 1; i++) begin
      if (i > 0) @(negedge clk);
      dmem_ack = (i == TO);
      #1;
      if (bus_err) n_berr++;
      @(posedge clk); #1;
    end
    sb_check("lastack");
    chk("lastack.bus_err_cnt", 32'(n_berr), 32'd0);

    // Misaligned load at 0x42.
    @(negedge clk);
    drive(2'b11, 3'b010, 32'h42, 32'h0, 5'd4, 1'b0, 1'b1, 32'h13579BDF);
`ifdef MEM_MISALIGN_CHECK_EN
    sb_q.push_back('{wb: 2'b00, rd: 32'd0, alu: 32'h200, rdrt: 5'd9});
    #1;
    chk("mis.dmem_req", 32'(dmem_req), 32'd0);
    chk("mis.misalign", 32'(misalign), 32'd1);
    chk("mis.stall",    32'(stall),    32'd0);
`else
    sb_q.push_back('{wb: 2'b11, rd: 32'h13579BDF, alu: 32'h42, rdrt: 5'd4});
    #1;
    chk("mis.dmem_req",  32'(dmem_req), 32'd1);
    chk("mis.dmem_addr", dmem_addr,     32'h42);
    chk("mis.misalign",  32'(misalign), 32'd0);
`endif
    @(posedge clk); #1;
    sb_check("mis");

    // Reset while BUSY abandons the access silently.
    @(negedge clk);
    drive(2'b11, 3'b010, 32'h300, 32'h0, 5'd6, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstb.dmem_req", 32'(dmem_req), 32'd1);
    chk("rstb.stall",    32'(stall),    32'd0);
    chk("rstb.bus_err",  32'(bus_err),  32'd0);
    @(posedge clk); #1;
    chk("rstb.ALUReg",   ALUReg,        32'd0);
    chk("rstb.ReadData", ReadData,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rstb.idle.dmem_req", 32'(dmem_req), 32'd0);
    chk("rstb.idle.stall",    32'(stall),    32'd0);

    chk("sb.empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
